fft_frame_ctrl: RTL and testbench

Frame sequencer in front of the 2^N-point radix-2 pipeline FFT core. It holds off FFT input for a warm-up interval after reset while the input FIFO leaves its reset state. It gates ADC samples into whole 2^N-sample frames in single-shot or continuous mode, and tracks completed output frames from `dout_en`/`dout_cnt`. It sits between the ADC capture logic and the FFT core and reports progress and errors to the system controller.

---
 rtl/fft_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer in front of a 2^N-point pipeline FFT.
// Holds off FFT input during a post-reset warm-up, gates ADC samples into
// whole frames (single-shot or continuous), and tracks completed output
// frames and outstanding work, flagging drain timeouts and overflow.
module fft_frame_ctrl #(
    parameter int WIDTH   = 16,
    parameter int N       = 9,
    parameter int WARMUP  = 10,
    parameter int TIMEOUT = 2048
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    stop,
    input  logic                    adc_valid,
    input  logic signed [WIDTH-1:0] adc_data,
    output logic                    din_en,
    output logic signed [WIDTH-1:0] din_ad,
    input  logic                    dout_en,
    input  logic [N-1:0]            dout_cnt,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frames,
    output logic                    err
);

    localparam int unsigned WW = $clog2(WARMUP + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_WARM,
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic                    w_timeout;
    logic                    w_done;
    logic                    w_boundary;
    logic                    w_inc;
    logic                    w_dec;

    logic [WW-1:0]           r_wcnt;
    logic [TW-1:0]           r_tcnt;
    logic [N-1:0]            r_scnt;
    logic [2:0]              r_outst;
    logic                    r_pend;
    logic                    r_mode;
    logic                    r_stop_pend;
    logic                    r_din_en;
    logic signed [WIDTH-1:0] r_din_ad;
    logic                    r_frame_done;
    logic [15:0]             r_frames;
    logic                    r_err;

    assign w_done     = dout_en && (dout_cnt == '1);
    assign w_boundary = (r_state == S_FEED) && adc_valid && (r_scnt == '1);
    // A boundary and a completion in the same cycle cancel out.
    assign w_inc      = w_boundary && !w_done;
    assign w_dec      = w_done && !w_boundary;

    // State register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) r_state <= S_WARM;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic plus capture-accept and drain-timeout strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_WARM: begin
                if (r_wcnt == WW'(WARMUP)) begin
                    if (r_pend || start) begin
                        w_state_nxt = S_FEED;
                        w_accept    = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (start || r_pend) begin
                    w_state_nxt = S_FEED;
                    w_accept    = 1'b1;
                end
            end
            S_FEED: begin
                if (w_boundary && (!r_mode || r_stop_pend || stop))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_outst == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_WARM;
        endcase
    end

    // Warm-up and drain-timeout counters.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_wcnt <= '0;
            r_tcnt <= '0;
        end else begin
            if (r_state == S_WARM && r_wcnt != WW'(WARMUP)) r_wcnt <= r_wcnt + WW'(1);
            else                                            r_wcnt <= '0;
            if (r_state == S_DRAIN && !w_done) r_tcnt <= r_tcnt + TW'(1);
            else                               r_tcnt <= '0;
        end
    end

    // Capture control: pending start, latched mode, pending stop, sample count.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_pend      <= 1'b0;
            r_mode      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_scnt      <= '0;
        end else begin
            if (w_accept)                      r_pend <= 1'b0;
            else if (r_state == S_WARM && start) r_pend <= 1'b1;

            if ((r_state == S_WARM || r_state == S_IDLE) && start) r_mode <= mode;

            if (w_accept)                       r_stop_pend <= 1'b0;
            else if (r_state == S_FEED && stop) r_stop_pend <= 1'b1;

            if (w_accept)                            r_scnt <= '0;
            else if (r_state == S_FEED && adc_valid) r_scnt <= r_scnt + N'(1);
        end
    end

    // FFT input stage: one-cycle registered pass-through of ADC samples.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_din_en <= 1'b0;
            r_din_ad <= '0;
        end else begin
            r_din_en <= (r_state == S_FEED) && adc_valid;
            r_din_ad <= adc_data;
        end
    end

    // Output-frame tracking, outstanding-frame count and sticky error.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_frame_done <= 1'b0;
            r_frames     <= '0;
            r_outst      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            if (w_done) r_frames <= r_frames + 16'd1;

            if (w_timeout)                      r_outst <= '0;
            else if (w_inc && r_outst != 3'd7)  r_outst <= r_outst + 3'd1;
            else if (w_dec && r_outst != 3'd0)  r_outst <= r_outst - 3'd1;

            if (w_accept)                                      r_err <= 1'b0;
            else if (w_timeout || (w_inc && r_outst == 3'd7))  r_err <= 1'b1;
        end
    end

    assign din_en     = r_din_en;
    assign din_ad     = r_din_ad;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign frames     = r_frames;
    assign err        = r_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: warm-up latency, single/continuous
// framing, stop handling, drain timeout, async reset abort, coincident
// boundary/completion and outstanding-count overflow.
module tb_fft_frame_ctrl;

    localparam int WIDTH   = 16;
    localparam int N       = 9;
    localparam int WARMUP  = 10;
    localparam int TIMEOUT = 2048;

    logic                    clk;
    logic                    areset;
    logic                    start;
    logic                    mode;
    logic                    stop;
    logic                    adc_valid;
    logic signed [WIDTH-1:0] adc_data;
    logic                    din_en;
    logic signed [WIDTH-1:0] din_ad;
    logic                    dout_en;
    logic [N-1:0]            dout_cnt;
    logic                    busy;
    logic                    frame_done;
    logic [15:0]             frames;
    logic                    err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic signed [WIDTH-1:0] last_data;

    fft_frame_ctrl #(
        .WIDTH  (WIDTH),
        .N      (N),
        .WARMUP (WARMUP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .start     (start),
        .mode      (mode),
        .stop      (stop),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .din_en    (din_en),
        .din_ad    (din_ad),
        .dout_en   (dout_en),
        .dout_cnt  (dout_cnt),
        .busy      (busy),
        .frame_done(frame_done),
        .frames    (frames),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        last_data = adc_data;
        @(posedge clk);
        #1;
        cyc++;
        adc_data = WIDTH'($urandom);
    endtask

    // One completed output frame from the FFT.
    task automatic complete_frame();
        dout_en  = 1'b1;
        dout_cnt = 9'd511;
        step();
        dout_en  = 1'b0;
    endtask

    initial begin
        int s;
        int x;
        int y;
        int cnt;
        int first;
        int last;
        int exp_frames;

        areset    = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        stop      = 1'b0;
        adc_valid = 1'b1;
        adc_data  = '0;
        dout_en   = 1'b0;
        dout_cnt  = '0;
        exp_frames = 0;

        // ---- reset state
        step();
        step();
        check("rst_din_en", din_en, 0);
        check("rst_din_ad", din_ad, 0);
        check("rst_busy", busy, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_frames", frames, 0);
        check("rst_err", err, 0);

        // ---- 1: start during warm-up, first din_en at WARMUP+2, 512 samples
        areset = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 530; i++) begin
            step();
            check("t1_din_en", din_en, (cyc >= WARMUP + 2 && cyc <= WARMUP + 2 + 511) ? 1 : 0);
            if (din_en) check("t1_din_ad", din_ad, last_data);
            start = (cyc == 3);
        end
        adc_valid = 1'b0;
        complete_frame();
        exp_frames++;
        check("t1_frame_done", frame_done, 1);
        check("t1_frames", frames, exp_frames);
        check("t1_busy_drain", busy, 1);
        step();
        check("t1_busy_idle", busy, 0);
        check("t1_frame_done_pulse", frame_done, 0);

        // ---- 2: single mode with alternating valid
        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 1100; i++) begin
            adc_valid = (i % 2 == 0);
            step();
            if (din_en) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        adc_valid = 1'b0;
        check("t2_din_count", cnt, 512);
        check("t2_first", first, 0);
        check("t2_span", last - first, 1022);
        check("t2_busy_drain", busy, 1);
        check("t2_err", err, 0);
        dout_en = 1'b1; dout_cnt = 9'd510;
        step();
        check("t2_cnt510_no_done", frame_done, 0);
        dout_en = 1'b0; dout_cnt = 9'd511;
        step();
        check("t2_en0_no_done", frame_done, 0);
        check("t2_frames_hold", frames, exp_frames);
        complete_frame();
        exp_frames++;
        check("t2_frame_done", frame_done, 1);
        check("t2_frames", frames, exp_frames);
        step();
        check("t2_busy_idle", busy, 0);

        // ---- 3: continuous, stop in the third frame
        adc_valid = 1'b1;
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        mode  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            stop = (i == 1200);
            step();
            if (din_en) cnt++;
        end
        stop = 1'b0;
        check("t3_din_count", cnt, 1536);
        check("t3_busy_drain", busy, 1);
        for (int k = 0; k < 3; k++) begin
            complete_frame();
            exp_frames++;
            check("t3_frame_done", frame_done, 1);
            step();
            check("t3_busy", busy, (k == 2) ? 0 : 1);
        end
        check("t3_frames", frames, exp_frames);
        check("t3_err", err, 0);

        // ---- 4: drain timeout with no FFT output
        start = 1'b1;
        mode  = 1'b0;
        s = cyc;
        step();
        start = 1'b0;
        while (cyc < s + 1 + 512 + TIMEOUT - 1) begin
            step();
            if (cyc == s + 513) check("t4_last_din", din_en, 1);
            if (cyc == s + 514) check("t4_drain_din", din_en, 0);
        end
        check("t4_err_before", err, 0);
        check("t4_busy_before", busy, 1);
        step();
        check("t4_err_timeout", err, 1);
        check("t4_busy_after", busy, 0);
        step();
        check("t4_err_sticky", err, 1);
        start = 1'b1;
        x = cyc;
        step();
        start = 1'b0;
        check("t4_err_cleared", err, 0);
        check("t4_busy_feed", busy, 1);

        // ---- 5: async reset mid-frame at sample 200
        while (cyc < x + 201) step();
        #2;
        areset = 1'b0;
        #1;
        check("t5_async_din_en", din_en, 0);
        check("t5_async_din_ad", din_ad, 0);
        check("t5_async_busy", busy, 1);
        check("t5_async_frames", frames, 0);
        check("t5_async_err", err, 0);
        check("t5_async_frame_done", frame_done, 0);
        exp_frames = 0;
        @(posedge clk);
        #1;
        areset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5_warm_din_en", din_en, 0);
            if (cyc == WARMUP)     check("t5_busy_warm", busy, 1);
            if (cyc == WARMUP + 1) check("t5_busy_idle", busy, 0);
        end
        start = 1'b1;
        y = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < 520; i++) begin
            step();
            check("t5_din_en", din_en, (cyc >= y + 2 && cyc <= y + 513) ? 1 : 0);
        end
        complete_frame();
        exp_frames++;
        check("t5_frames", frames, exp_frames);
        step();
        check("t5_busy_idle2", busy, 0);

        // ---- 6: continuous, frame boundary coincident with completion
        start = 1'b1;
        mode  = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        while (cyc < s + 1024) step();
        stop     = 1'b1;
        dout_en  = 1'b1;
        dout_cnt = 9'd511;
        step();
        stop    = 1'b0;
        dout_en = 1'b0;
        exp_frames++;
        check("t6_frame_done", frame_done, 1);
        check("t6_frames", frames, exp_frames);
        check("t6_err", err, 0);
        check("t6_last_din", din_en, 1);
        step();
        check("t6_drain_din", din_en, 0);
        step();
        step();
        step();
        check("t6_busy_outstanding", busy, 1);
        complete_frame();
        exp_frames++;
        check("t6_frame_done2", frame_done, 1);
        step();
        check("t6_busy_idle", busy, 0);
        check("t6_err_end", err, 0);
        check("t6_frames_end", frames, exp_frames);

        // ---- 7: outstanding overflow after eight frames with no output
        start = 1'b1;
        mode  = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        while (cyc < s + 1 + 512 * 7 + 1) step();
        check("t7_err_at7", err, 0);
        while (cyc < s + 1 + 512 * 8 - 1) step();
        check("t7_err_before8", err, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t7_err_overflow", err, 1);
        check("t7_busy_drain", busy, 1);
        step();
        check("t7_drain_din", din_en, 0);
        for (int k = 0; k < 7; k++) begin
            complete_frame();
            exp_frames++;
            step();
            check("t7_busy", busy, (k == 6) ? 0 : 1);
        end
        check("t7_frames", frames, exp_frames);
        check("t7_err_sticky", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
